// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem request,
// IF/ID pipeline register, one-entry stall buffer and wrong-path response kill.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_pc_plus4,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buffer;
    logic [31:0] kill_addr;
    logic [31:0] target;
    logic [31:0] pc_next;

    assign target    = {branch_target[31:2], 2'b00};
    assign pc_next   = pc + 32'd4;
    // In KILL the wrong-path request must stay on the bus until memory accepts it.
    assign imem_addr = (state == KILL) ? kill_addr : pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            imem_req       <= 1'b0;
            pc             <= RESET_PC;
            buffer         <= NOP_INSTR;
            kill_addr      <= 32'h0;
            IF_ID_pc       <= 32'h0;
            IF_ID_pc_plus4 <= 32'h4;
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (flush) begin
                        pc          <= target;
                        IF_ID_instr <= NOP_INSTR;
                        IF_ID_valid <= 1'b0;
                        if (!imem_ready) begin
                            kill_addr <= pc;
                            state     <= KILL;
                        end
                    end else if (imem_ready && !stall) begin
                        IF_ID_pc       <= pc;
                        IF_ID_pc_plus4 <= pc_next;
                        IF_ID_instr    <= imem_rdata;
                        IF_ID_valid    <= 1'b1;
                        pc             <= pc_next;
                    end else if (imem_ready) begin
                        buffer   <= imem_rdata;
                        state    <= HOLD;
                        imem_req <= 1'b0;
                    end else if (!stall) begin
                        IF_ID_instr <= NOP_INSTR;
                        IF_ID_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        buffer      <= NOP_INSTR;
                        pc          <= target;
                        IF_ID_instr <= NOP_INSTR;
                        IF_ID_valid <= 1'b0;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end else if (!stall) begin
                        IF_ID_pc       <= pc;
                        IF_ID_pc_plus4 <= pc_next;
                        IF_ID_instr    <= buffer;
                        IF_ID_valid    <= 1'b1;
                        pc             <= pc_next;
                        state          <= FETCH;
                        imem_req       <= 1'b1;
                    end
                end
                KILL: begin
                    if (flush)
                        pc <= target;
                    if (imem_ready)
                        state <= FETCH;
                    if (!stall) begin
                        IF_ID_instr <= NOP_INSTR;
                        IF_ID_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
